// File: rtl/ilf_deser_nx_if.sv
// ilf_deser_nx_if: serial-in / parallel-out bundle for ilf_deser_nx.
//   D      : serial data, one bit per lane
//   SP     : bit-accept enable
//   ALIGN  : bitslip request (rising edge)
//   Q      : parallel words, lane c at Q[c*RATIO +: RATIO]
//   QVALID : one-cycle strobe marking a Q update
//   PHASE  : current bit counter
//   SLIPS  : executed slips, modulo RATIO
// master drives D/SP/ALIGN, slave (the deserializer) drives the rest.
interface ilf_deser_nx_if #(
    parameter int WIDTH = 4,
    parameter int RATIO = 4
);
    localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [WIDTH-1:0]       D;
    logic                   SP;
    logic                   ALIGN;
    logic [WIDTH*RATIO-1:0] Q;
    logic                   QVALID;
    logic [PW-1:0]          PHASE;
    logic [PW-1:0]          SLIPS;

    modport master (output D, SP, ALIGN, input Q, QVALID, PHASE, SLIPS);
    modport slave  (input D, SP, ALIGN, output Q, QVALID, PHASE, SLIPS);
endinterface

// File: rtl/ilf_deser_nx.sv
// ilf_deser_nx: WIDTH-lane serial-to-parallel deserializer with bitslip.
//   CK  : clock, all registers rising edge
//   CD  : asynchronous active-high clear
//   bus : ilf_deser_nx_if.slave (D, SP, ALIGN in; Q, QVALID, PHASE, SLIPS out)
// Each lane registers D every cycle, shifts the registered bit into a
// RATIO-bit word on SP, and loads Q when the shared counter wraps. A rising
// ALIGN on an SP cycle freezes the counter for one bit, moving the word
// boundary by one position.

// Per-lane datapath: capture flop, shift register and output word.
module ilf_deser_nx_lane #(
    parameter int RATIO = 4
) (
    input  logic             CK,
    input  logic             clr_i,
    input  logic             d_i,
    input  logic             sp_i,
    input  logic             emit_i,
    output logic [RATIO-1:0] q_o
);
    logic             r_q;
    logic [RATIO-2:0] sh_q;    // only the newest RATIO-1 bits are ever needed
    logic [RATIO-1:0] q_q;
    logic [RATIO-1:0] word;

    // Oldest bit at the MSB, freshly registered bit at the LSB.
    assign word = {sh_q, r_q};

    always_ff @(posedge CK or posedge clr_i) begin
        if (clr_i) begin
            r_q  <= 1'b0;
            sh_q <= '0;
            q_q  <= '0;
        end else begin
            r_q <= d_i;
            if (sp_i)   sh_q <= word[RATIO-2:0];
            if (emit_i) q_q  <= word;
        end
    end

    assign q_o = q_q;
endmodule

module ilf_deser_nx #(
    parameter int WIDTH = 4,
    parameter int RATIO = 4,
    parameter     GSR   = "ENABLED"
) (
    input logic          CK,
    input logic          CD,
    ilf_deser_nx_if.slave bus
);
    localparam int            PW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PW-1:0] LAST     = PW'(RATIO - 1);
    localparam logic          DATA_CLR = (GSR == "ENABLED");

    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] slips_q, slips_d;
    logic          a_q;
    logic          qvalid_q, qvalid_d;
    logic          slip, emit;
    logic          data_clr;

    logic [WIDTH-1:0][RATIO-1:0] q_w;

    // With GSR disabled the data registers never see the clear.
    assign data_clr = CD & DATA_CLR;

    always_comb begin
        slip     = bus.SP & bus.ALIGN & ~a_q;
        emit     = bus.SP & ~slip & (cnt_q == LAST);
        cnt_d    = cnt_q;
        slips_d  = slips_q;
        qvalid_d = emit;
        // A slip still shifts the bit in but does not count it, so the
        // next word boundary lands one bit later.
        if (bus.SP && !slip)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (slip)
            slips_d = (slips_q == LAST) ? '0 : slips_q + 1'b1;
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            cnt_q    <= '0;
            slips_q  <= '0;
            a_q      <= 1'b0;
            qvalid_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            slips_q  <= slips_d;
            a_q      <= bus.ALIGN;
            qvalid_q <= qvalid_d;
        end
    end

    for (genvar c = 0; c < WIDTH; c++) begin : g_lane
        ilf_deser_nx_lane #(.RATIO(RATIO)) u_lane (
            .CK     (CK),
            .clr_i  (data_clr),
            .d_i    (bus.D[c]),
            .sp_i   (bus.SP),
            .emit_i (emit),
            .q_o    (q_w[c])
        );
    end

    assign bus.Q      = q_w;
    assign bus.QVALID = qvalid_q;
    assign bus.PHASE  = cnt_q;
    assign bus.SLIPS  = slips_q;
endmodule

// File: tb/tb_ilf_deser_nx.sv
module tb_ilf_deser_nx;
    logic       ck = 1'b0;
    logic       cd = 1'b1;
    logic [1:0] d  = 2'b00;
    logic       sp = 1'b0;
    logic       al = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 ck = ~ck;

    ilf_deser_nx_if #(.WIDTH(2), .RATIO(4)) bus1 ();
    ilf_deser_nx_if #(.WIDTH(2), .RATIO(4)) bus2 ();

    assign bus1.D = d;  assign bus1.SP = sp;  assign bus1.ALIGN = al;
    assign bus2.D = d;  assign bus2.SP = sp;  assign bus2.ALIGN = al;

    ilf_deser_nx #(.WIDTH(2), .RATIO(4), .GSR("ENABLED"))  dut1 (.CK(ck), .CD(cd), .bus(bus1));
    ilf_deser_nx #(.WIDTH(2), .RATIO(4), .GSR("DISABLED")) dut2 (.CK(ck), .CD(cd), .bus(bus2));

    // Reference model: history of accepted bits (both lanes per entry),
    // count of counted bits and of executed slips.
    logic [1:0] m_r;
    logic [1:0] hist[$];
    int         m_adv, m_slips;
    logic       m_a, m_qv;
    logic [7:0] m_q;

    task automatic model_reset();
        m_r = 2'b00; hist.delete(); m_adv = 0; m_slips = 0;
        m_a = 1'b0; m_qv = 1'b0; m_q = 8'h00;
    endtask

    task automatic model_step(input logic [1:0] dv, input logic spv, input logic alv);
        bit slip;
        slip = spv && alv && !m_a;
        m_qv = 1'b0;
        if (spv) begin
            hist.push_back(m_r);
            if (hist.size() > 8) void'(hist.pop_front());
            if (slip) m_slips++;
            else begin
                m_adv++;
                if (m_adv % 4 == 0) begin
                    m_qv = 1'b1;
                    for (int c = 0; c < 2; c++)
                        for (int k = 0; k < 4; k++)
                            m_q[c*4 + 3 - k] = hist[hist.size() - 4 + k][c];
                end
            end
        end
        m_a = alv;
        m_r = dv;
    endtask

    task automatic tick(input logic [1:0] dv, input logic spv, input logic alv);
        d = dv; sp = spv; al = alv;
        @(posedge ck);
        model_step(dv, spv, alv);
        #1;
    endtask

    task automatic do_reset();
        cd = 1'b1;
        @(posedge ck);
        #1;
        cd = 1'b0;
        model_reset();
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            d = 2'($urandom);
            @(posedge ck);
            #1;
            n_chk++;
            if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== 13'd0) begin
                n_err++;
                $display("FAIL reset_hold: got Q=%h V=%b P=%0d S=%0d want all zero",
                         bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS);
            end
        end
        cd = 1'b0;
        model_reset();
        tick(2'($urandom), 1'b0, 1'b0);
        n_chk++;
        if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_release: got Q=%h V=%b P=%0d S=%0d want all zero",
                     bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS);
        end
    endtask

    task automatic test_continuous();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        do_reset();
        // first bit is registered on a non-accepting edge, then SP runs
        for (int e = 1; e <= 9; e++) begin
            logic b;
            b = (e <= 8) ? pat[8-e] : 1'b0;
            tick({~b, b}, (e != 1), 1'b0);
            n_chk++;
            if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== {m_q, m_qv, 2'(m_adv % 4), 2'(m_slips % 4)}) begin
                n_err++;
                $display("FAIL cont_model e%0d: got Q=%h V=%b P=%0d S=%0d want Q=%h V=%b P=%0d S=%0d",
                         e, bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS, m_q, m_qv, m_adv % 4, m_slips % 4);
            end
            n_chk++;
            if (bus1.QVALID !== (e == 5 || e == 9)) begin
                n_err++;
                $display("FAIL cont_qvalid e%0d: got %b want %b", e, bus1.QVALID, (e == 5 || e == 9));
            end
            if (e == 5 || e == 9) begin
                n_chk++;
                if (bus1.Q !== ((e == 5) ? 8'b0100_1011 : 8'b1101_0010)) begin
                    n_err++;
                    $display("FAIL cont_word e%0d: got %b want %b", e, bus1.Q,
                             (e == 5) ? 8'b0100_1011 : 8'b1101_0010);
                end
            end
        end
    endtask

    task automatic test_sp_gated();
        logic [3:0] pat;
        logic [1:0] ph;
        pat = 4'b1101;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] dv;
            dv = {rb(), pat[3-i]};
            for (int s = 0; s < 2; s++) begin
                ph = bus1.PHASE;
                tick(dv, (s == 1), 1'b0);
                n_chk++;
                if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== {m_q, m_qv, 2'(m_adv % 4), 2'(m_slips % 4)}) begin
                    n_err++;
                    $display("FAIL gated_model: got Q=%h V=%b P=%0d S=%0d want Q=%h V=%b P=%0d S=%0d",
                             bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS, m_q, m_qv, m_adv % 4, m_slips % 4);
                end
                n_chk++;
                if (s == 0 && bus1.PHASE !== ph) begin
                    n_err++;
                    $display("FAIL gated_phase_hold: got %0d want %0d", bus1.PHASE, ph);
                end
            end
        end
        n_chk++;
        if (bus1.QVALID !== 1'b1 || bus1.Q[3:0] !== 4'b1101) begin
            n_err++;
            $display("FAIL gated_word: got V=%b Q=%b want V=1 Q=1101", bus1.QVALID, bus1.Q[3:0]);
        end
    endtask

    task automatic test_align();
        int idx;
        idx = 0;
        do_reset();
        tick({rb(), 1'(idx % 4 == 3)}, 1'b0, 1'b0); idx++;
        for (int i = 0; i < 8; i++) begin
            tick({rb(), 1'(idx % 4 == 3)}, 1'b1, 1'b0); idx++;
            n_chk++;
            if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== {m_q, m_qv, 2'(m_adv % 4), 2'(m_slips % 4)}) begin
                n_err++;
                $display("FAIL align_pre: got Q=%h V=%b P=%0d S=%0d want Q=%h V=%b P=%0d S=%0d",
                         bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS, m_q, m_qv, m_adv % 4, m_slips % 4);
            end
        end
        for (int i = 0; i < 4 && (m_adv % 4) != 3; i++) begin
            tick({rb(), 1'(idx % 4 == 3)}, 1'b1, 1'b0); idx++;
        end
        tick({rb(), 1'(idx % 4 == 3)}, 1'b1, 1'b1); idx++;
        n_chk++;
        if (bus1.QVALID !== 1'b0 || bus1.SLIPS !== 2'd1 || bus1.PHASE !== 2'd3) begin
            n_err++;
            $display("FAIL align_slip: got V=%b S=%0d P=%0d want V=0 S=1 P=3",
                     bus1.QVALID, bus1.SLIPS, bus1.PHASE);
        end
        tick({rb(), 1'(idx % 4 == 3)}, 1'b1, 1'b0); idx++;
        n_chk++;
        if (bus1.QVALID !== 1'b1 || bus1.Q[3:0] !== 4'b0010) begin
            n_err++;
            $display("FAIL align_shifted: got V=%b Q=%b want V=1 Q=0010", bus1.QVALID, bus1.Q[3:0]);
        end
        for (int i = 0; i < 13; i++) begin
            // ALIGN held high for 5 cycles, then a rising edge on an SP=0 cycle
            logic spv, alv;
            spv = !(i == 9);
            alv = (i >= 2 && i < 7) || (i == 9) || (i == 10);
            tick({rb(), 1'(idx % 4 == 3)}, spv, alv);
            if (spv) idx++;
            n_chk++;
            if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== {m_q, m_qv, 2'(m_adv % 4), 2'(m_slips % 4)}) begin
                n_err++;
                $display("FAIL align_post i%0d: got Q=%h V=%b P=%0d S=%0d want Q=%h V=%b P=%0d S=%0d",
                         i, bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS, m_q, m_qv, m_adv % 4, m_slips % 4);
            end
        end
        n_chk++;
        if (bus1.SLIPS !== 2'd2) begin
            n_err++;
            $display("FAIL align_slip_count: got %0d want 2", bus1.SLIPS);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick({rb(), 1'b1}, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick({rb(), 1'b1}, 1'b1, 1'b0);
        n_chk++;
        if (bus1.PHASE !== 2'd2 || bus1.Q[3:0] !== 4'b1111) begin
            n_err++;
            $display("FAIL arst_setup: got P=%0d Q=%b want P=2 Q=1111", bus1.PHASE, bus1.Q[3:0]);
        end
        #3 cd = 1'b1;
        #1;
        n_chk++;
        if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== 13'd0) begin
            n_err++;
            $display("FAIL arst_immediate: got Q=%h V=%b P=%0d S=%0d want all zero",
                     bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS);
        end
        cd = 1'b0;
        model_reset();
        for (int n = 1; n <= 4; n++) begin
            tick({rb(), rb()}, 1'b1, 1'b0);
            n_chk++;
            if (bus1.QVALID !== (n == 4)) begin
                n_err++;
                $display("FAIL arst_fresh n%0d: got V=%b want %b", n, bus1.QVALID, (n == 4));
            end
            n_chk++;
            if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== {m_q, m_qv, 2'(m_adv % 4), 2'(m_slips % 4)}) begin
                n_err++;
                $display("FAIL arst_model n%0d: got Q=%h V=%b P=%0d S=%0d want Q=%h V=%b P=%0d S=%0d",
                         n, bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS, m_q, m_qv, m_adv % 4, m_slips % 4);
            end
        end
    endtask

    task automatic test_gsr_disabled();
        do_reset();
        tick({rb(), 1'b1}, 1'b0, 1'b0);
        tick({rb(), 1'b0}, 1'b1, 1'b0);
        tick({rb(), 1'b1}, 1'b1, 1'b0);
        tick({rb(), 1'b1}, 1'b1, 1'b0);
        tick({rb(), 1'b0}, 1'b1, 1'b0);
        n_chk++;
        if (bus2.QVALID !== 1'b1 || bus2.Q[3:0] !== 4'b1011) begin
            n_err++;
            $display("FAIL nogsr_emit: got V=%b Q=%b want V=1 Q=1011", bus2.QVALID, bus2.Q[3:0]);
        end
        tick({rb(), rb()}, 1'b1, 1'b0);
        #3 cd = 1'b1;
        #1;
        n_chk++;
        if (bus2.Q[3:0] !== 4'b1011 || bus2.QVALID !== 1'b0 || bus2.PHASE !== 2'd0 || bus2.SLIPS !== 2'd0) begin
            n_err++;
            $display("FAIL nogsr_clear: got Q=%b V=%b P=%0d S=%0d want Q=1011 V=0 P=0 S=0",
                     bus2.Q[3:0], bus2.QVALID, bus2.PHASE, bus2.SLIPS);
        end
        n_chk++;
        if (bus1.Q !== 8'h00) begin
            n_err++;
            $display("FAIL gsr_clear: got Q=%h want 00", bus1.Q);
        end
        #1 cd = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic alv;
        alv = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) alv = ~alv;
            tick(2'($urandom), ($urandom_range(0, 3) != 0), alv);
            n_chk++;
            if ({bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS} !== {m_q, m_qv, 2'(m_adv % 4), 2'(m_slips % 4)}) begin
                n_err++;
                $display("FAIL random i%0d: got Q=%h V=%b P=%0d S=%0d want Q=%h V=%b P=%0d S=%0d",
                         i, bus1.Q, bus1.QVALID, bus1.PHASE, bus1.SLIPS, m_q, m_qv, m_adv % 4, m_slips % 4);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_continuous();
        test_sp_gated();
        test_align();
        test_async_reset();
        test_gsr_disabled();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
